// File: rtl/enoc_credit_switch_allocator.sv
// Credit-based switch allocator: per-output round-robin arbiter gated by a
// credit counter that mirrors free slots in the downstream input queue.

module enoc_sa_out_port #(
  parameter int N       = 5,
  parameter int CREDITS = 4,
  parameter int PTR_W   = 3,
  parameter int CRD_W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [0:N-1] cand_i,
  input  logic         credit_ret_i,
  output logic [0:N-1] grant_o,
  output logic         avail_o,
  output logic         ovf_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CRD_W-1:0] credit_q, credit_d;
  logic [PTR_W-1:0] gidx;
  logic             found;
  int               idx;

  assign avail_o = (credit_q != '0);
  assign ovf_o   = credit_ret_i && (credit_q == CRD_W'(CREDITS));

  // Search starts at the pointer and wraps; reset forces the grant low.
  always_comb begin
    grant_o = '0;
    gidx    = '0;
    found   = 1'b0;
    idx     = 0;
    if (!reset && ce && avail_o) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr_q) + k) % N;
        if (!found && cand_i[idx]) begin
          found = 1'b1;
          gidx  = PTR_W'(idx);
        end
      end
    end
    if (found) grant_o[gidx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (gidx == PTR_W'(N-1)) ? '0 : gidx + 1'b1;
  end

  // Grant and return in the same cycle cancel; a return at full saturates.
  always_comb begin
    credit_d = credit_q;
    unique case ({found, credit_ret_i})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = (credit_q == CRD_W'(CREDITS)) ? credit_q : credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      credit_q <= CRD_W'(CREDITS);
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

endmodule

module enoc_credit_switch_allocator #(
  parameter int N       = 5,
  parameter int M       = 5,
  parameter int CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic [0:N-1][0:M-1]  i_output_req,
  input  logic [0:M-1]         i_credit_return,
  output logic [0:M-1][0:N-1]  o_output_grant,
  output logic [0:M-1]         o_credit_avail,
  output logic                 o_credit_err
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CRD_W = $clog2(CREDITS + 1);

  logic [0:N-1][0:M-1] req_san;
  logic [0:M-1][0:N-1] cand;
  logic [0:M-1]        ovf;
  logic                hit;
  logic                err_q, err_d;

  // Keep only the lowest-index request bit so each input wins at most once.
  always_comb begin
    req_san = '0;
    hit     = 1'b0;
    for (int i = 0; i < N; i++) begin
      hit = 1'b0;
      for (int j = 0; j < M; j++) begin
        if (!hit && i_output_req[i][j]) begin
          req_san[i][j] = 1'b1;
          hit           = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cand = '0;
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++)
        cand[j][i] = req_san[i][j];
  end

  for (genvar j = 0; j < M; j++) begin : g_port
    enoc_sa_out_port #(
      .N(N), .CREDITS(CREDITS), .PTR_W(PTR_W), .CRD_W(CRD_W)
    ) u_port (
      .clk         (clk),
      .reset       (reset),
      .ce          (ce),
      .cand_i      (cand[j]),
      .credit_ret_i(i_credit_return[j]),
      .grant_o     (o_output_grant[j]),
      .avail_o     (o_credit_avail[j]),
      .ovf_o       (ovf[j])
    );
  end

  assign err_d        = err_q | (|ovf);
  assign o_credit_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

endmodule
